// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: state encoding, data width, bit-period
//                counter width and the default bit period for 9600 baud at 50 MHz.
//                Used by both the transmit and receive paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_W              = 8;
  localparam int CNT_W               = 16;
  localparam int BIT_CYCLES_9600_50M = 5208;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the XOR of all data bits, so the total count of ones is even.
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period counter. Counts 0..BIT_CYCLES-1 and pulses bit_end_o
//                for one cycle on the last count, then wraps to 0. Holding
//                clr_i keeps the count at 0 and suppresses the pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_9600_50M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_w;

  assign last_w    = (cnt_q == LAST_CNT);
  assign bit_end_o = last_w && !clr_i;

  // Next count: wrap at the end of each bit, hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || last_w) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter with valid/ready byte input. Serialises
//                start bit, 8 data bits LSB first and stop bit, each lasting
//                BIT_CYCLES clocks. txd is registered from the current state,
//                so it lags the state by one clock and has no input-to-pin path.
//                Optional macro UART_TX_PARITY_EN adds an even-parity bit
//                before the stop bit (8E1 framing).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_9600_50M
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_data_valid,
  output logic              tx_data_ready,
  output logic              txd
);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;
  logic              txd_q, txd_d;
  logic              bit_end;

  // Counter idles at zero so a new frame always starts a full start bit.
  uart_baud_cnt #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == S_IDLE),
    .bit_end_o (bit_end)
  );

  assign tx_data_ready = (state_q == S_IDLE);
  assign txd           = txd_q;

  // Next-state, shift register capture, bit index and line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    txd_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_data_valid) begin
          shift_d = tx_data;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        txd_d = shift_q[idx_q];
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        // shift_q is never shifted, so this is the byte latched at handshake.
        txd_d = even_parity(shift_q);
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, data and line registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= 3'd0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

endmodule
`default_nettype wire
